// File: rtl/pc_pkg.sv
// Shared types and constants for the IF-stage program-counter generator.
// Holds the control-FSM encoding, the pending-request kinds and the fetch step sizes.
package pc_pkg;

  typedef logic [1:0] pc_state_e;
  localparam pc_state_e BOOT = 2'd0;
  localparam pc_state_e RUN  = 2'd1;
  localparam pc_state_e HALT = 2'd2;

  typedef logic [1:0] pend_kind_e;
  localparam pend_kind_e NONE   = 2'd0;
  localparam pend_kind_e BRANCH = 2'd1;
  localparam pend_kind_e TRAP   = 2'd2;

  localparam int unsigned STEP4 = 4;
  localparam int unsigned STEP2 = 2;

endpackage

// File: rtl/pc_redirect_hold.sv
// Pending redirect/trap target captured while fetch is halted; a pending trap is never
// displaced by a branch. The merged view (this cycle's capture included) is exposed for resume.
module pc_redirect_hold
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            capture_en,
  input  logic            clear,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            redirect_taken,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_target
);

  pend_kind_e      kind_q, kind_d;
  logic [XLEN-1:0] tgt_q, tgt_d;

  always_comb begin
    kind_d         = kind_q;
    tgt_d          = tgt_q;
    redirect_taken = 1'b0;
    if (capture_en) begin
      if (trap_valid) begin
        kind_d = TRAP;
        tgt_d  = trap_target;
      end else if (redirect_valid && (kind_q != TRAP)) begin
        kind_d         = BRANCH;
        tgt_d          = redirect_target;
        redirect_taken = 1'b1;
      end
    end
  end

  assign pend_valid  = (kind_d != NONE);
  assign pend_target = tgt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kind_q <= NONE;
      tgt_q  <= '0;
    end else if (clear) begin
      kind_q <= NONE;
    end else begin
      kind_q <= kind_d;
      tgt_q  <= tgt_d;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// IF-stage PC generator: BOOT/RUN/HALT control, trap > redirect > fetch priority, misalign check.
// Define PC_RVC_EN for 2/4-byte steps and 2-byte target alignment; default is 4-byte only.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VEC    = '0,
  parameter logic [XLEN-1:0] MISALIGN_VEC = XLEN'('h100)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pc_write,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            if_ready,
  input  logic            if_ilen16,
  output logic [XLEN-1:0] if_pc,
  output logic            if_valid,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr,
  output logic            halted
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            err_q, mis_detect;
  logic [XLEN-1:0] addr_q;

  logic            misaligned;
  logic [XLEN-1:0] step_amt;
  logic [XLEN-1:0] trap_target, redirect_target;
  logic            in_run, in_halt, resume_go;
  logic            hold_redirect_taken, pend_valid;
  logic [XLEN-1:0] pend_target;
  logic [2:0]      unused_bits;

`ifdef PC_RVC_EN
  assign misaligned = redirect_pc[0];
  assign step_amt   = if_ilen16 ? XLEN'(STEP2) : XLEN'(STEP4);
`else
  assign misaligned = |redirect_pc[1:0];
  assign step_amt   = XLEN'(STEP4);
`endif

  assign unused_bits     = {trap_pc[1:0], if_ilen16};
  assign trap_target     = {trap_pc[XLEN-1:2], 2'b00};
  assign redirect_target = misaligned ? MISALIGN_VEC : redirect_pc;

  assign in_run    = (state_q == RUN);
  assign in_halt   = (state_q == HALT);
  // halt_req beats resume when both arrive together
  assign resume_go = in_halt && resume && !halt_req;

  pc_redirect_hold #(.XLEN(XLEN)) u_hold (
    .clk             (clk),
    .reset_n         (reset_n),
    .capture_en      (in_halt),
    .clear           (resume_go),
    .trap_valid      (trap_valid),
    .trap_target     (trap_target),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .redirect_taken  (hold_redirect_taken),
    .pend_valid      (pend_valid),
    .pend_target     (pend_target)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mis_detect = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (trap_valid) begin
          pc_d = trap_target;
        end else if (redirect_valid) begin
          pc_d       = redirect_target;
          mis_detect = misaligned;
        end else if (pc_write && if_ready) begin
          pc_d = pc_q + step_amt;
        end
        if (halt_req) state_d = HALT;
      end
      HALT: begin
        mis_detect = hold_redirect_taken && misaligned;
        if (resume_go) begin
          state_d = RUN;
          if (pend_valid) pc_d = pend_target;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= mis_detect;
      if (mis_detect) addr_q <= redirect_pc;
    end
  end

  assign if_pc         = pc_q;
  assign if_valid      = in_run;
  assign halted        = in_halt;
  assign misalign_err  = err_q;
  assign misalign_addr = addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed and randomized checks of pc_gen against a request-log reference model.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] MV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n, pc_write, redirect_valid, trap_valid, halt_req, resume, if_ready, if_ilen16;
  logic [31:0] redirect_pc, trap_pc, if_pc, misalign_addr;
  logic        if_valid, misalign_err, halted;

  pc_gen #(.XLEN(32), .RESET_VEC(RV), .MISALIGN_VEC(MV)) dut (
    .clk(clk), .reset_n(reset_n), .pc_write(pc_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .halt_req(halt_req), .resume(resume),
    .if_ready(if_ready), .if_ilen16(if_ilen16),
    .if_pc(if_pc), .if_valid(if_valid),
    .misalign_err(misalign_err), .misalign_addr(misalign_addr), .halted(halted)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = booting, 1 = fetching, 2 = halted.
  // While halted, every accepted request is logged; resume picks the newest trap, else the newest branch.
  typedef struct { bit trap; logic [31:0] tgt; } req_t;
  req_t        req_log[$];
  int          m_mode;
  logic [31:0] m_pc, m_addr;
  logic        m_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  function automatic bit is_mis(input logic [31:0] a);
`ifdef PC_RVC_EN
    return a[0];
`else
    return a[1:0] != 2'b00;
`endif
  endfunction

  function automatic logic [31:0] step_of(input logic ilen16);
`ifdef PC_RVC_EN
    return ilen16 ? 32'd2 : 32'd4;
`else
    return 32'd4;
`endif
  endfunction

  function automatic bit log_has_trap();
    foreach (req_log[i]) if (req_log[i].trap) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_pc   = RV;
    m_err  = 1'b0;
    m_addr = 32'h0;
    req_log.delete();
  endtask

  task automatic model_edge();
    logic [31:0] rtgt;
    req_t        r;
    rtgt  = is_mis(redirect_pc) ? MV : redirect_pc;
    m_err = 1'b0;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (trap_valid) m_pc = trap_pc & 32'hFFFF_FFFC;
      else if (redirect_valid) begin
        m_pc = rtgt;
        if (is_mis(redirect_pc)) begin m_err = 1'b1; m_addr = redirect_pc; end
      end else if (pc_write && if_ready) m_pc = m_pc + step_of(if_ilen16);
      if (halt_req) m_mode = 2;
    end else begin
      if (trap_valid) begin
        r.trap = 1'b1; r.tgt = trap_pc & 32'hFFFF_FFFC; req_log.push_back(r);
      end else if (redirect_valid && !log_has_trap()) begin
        r.trap = 1'b0; r.tgt = rtgt; req_log.push_back(r);
        if (is_mis(redirect_pc)) begin m_err = 1'b1; m_addr = redirect_pc; end
      end
      if (resume && !halt_req) begin
        m_mode = 1;
        if (req_log.size() > 0) begin
          m_pc = req_log[req_log.size()-1].tgt;
          foreach (req_log[i]) if (req_log[i].trap) m_pc = req_log[i].tgt;
        end
        req_log.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("if_pc", if_pc, m_pc);
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_mode == 1});
    chk("halted", {31'b0, halted}, {31'b0, m_mode == 2});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
    chk("misalign_addr", misalign_addr, m_addr);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    redirect_valid = 1'b0; trap_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    #1 reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    reset_n = 1'b0; pc_write = 1'b0; if_ready = 1'b0; if_ilen16 = 1'b0;
    redirect_pc = 32'h0; trap_pc = 32'h0;
    idle();
    model_reset();
    #3;
    check_all();
    #9 reset_n = 1'b1;

    pc_write = 1'b1; if_ready = 1'b1;
    cycle(); chk("first_fetch_pc", if_pc, 32'h0);
    cycle(); chk("seq_pc4", if_pc, 32'h4);
    cycle(); chk("seq_pc8", if_pc, 32'h8);

    pc_write = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    cycle(); chk("redirect_over_stall", if_pc, 32'h40);
    trap_valid = 1'b1; trap_pc = 32'h83;
    cycle(); chk("trap_beats_redirect", if_pc, 32'h80);
    trap_valid = 1'b0; redirect_pc = 32'h42;
    cycle();
`ifdef PC_RVC_EN
    chk("rvc_target_42", if_pc, 32'h42);
`else
    chk("misalign_vec", if_pc, MV);
    chk("misalign_pulse", {31'b0, misalign_err}, 32'h1);
    chk("misalign_addr42", misalign_addr, 32'h42);
`endif
    idle();
    cycle(); chk("misalign_one_shot", {31'b0, misalign_err}, 32'h0);

    halt_req = 1'b1;
    cycle(); chk("halt_entered", {31'b0, halted}, 32'h1);
    halt_req = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h200; cycle();
    redirect_valid = 1'b0; trap_valid = 1'b1; trap_pc = 32'h300; cycle();
    trap_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h400; cycle();
    idle(); resume = 1'b1;
    cycle(); chk("resume_pending_trap", if_pc, 32'h300);
    idle();

    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; cycle();
    redirect_valid = 1'b0; pc_write = 1'b1; if_ready = 1'b1;
    cycle(); chk("pc_wrap", if_pc, 32'h0);

    pc_write = 1'b0; halt_req = 1'b1; cycle();
    halt_req = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h500; cycle();
    idle();
    do_reset(); chk("reset_mid_halt_pc", if_pc, RV);
    cycle();
    halt_req = 1'b1; cycle();
    halt_req = 1'b0; resume = 1'b1;
    cycle(); chk("pending_cleared_by_reset", if_pc, RV);
    idle();

    for (int i = 0; i < 800; i++) begin
      pc_write       = ($urandom_range(0, 3) != 0);
      if_ready       = ($urandom_range(0, 3) != 0);
      if_ilen16      = $urandom_range(0, 1);
      redirect_valid = ($urandom_range(0, 7) == 0);
      trap_valid     = ($urandom_range(0, 15) == 0);
      halt_req       = ($urandom_range(0, 11) == 0);
      resume         = ($urandom_range(0, 3) == 0);
      r = $urandom;
      if ($urandom_range(0, 1) == 1) r[1:0] = 2'b00;
      redirect_pc = r;
      trap_pc     = $urandom;
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
